// File: rtl/fetch_entry_buffer_pkg.sv
// Packages used by the fetch entry buffer slice.
//  - config_pkg / ariane_pkg: minimal stand-ins for the core packages so this
//    slice elaborates on its own. They carry only the fields the buffer needs.
//  - fetch_entry_buffer_pkg: parameter legality helper used by the buffer.

package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] instruction;
    exception_t  ex;
  } fetch_entry_t;

endpackage

package fetch_entry_buffer_pkg;

  localparam int unsigned FEB_MIN_DEPTH = 2;

  // Pointers wrap naturally, so only power-of-two depths are legal.
  function automatic bit depth_is_valid(int unsigned depth);
    return (depth >= FEB_MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_entry_buffer.sv
// fetch_entry_buffer: elastic buffer between frontend fetch-entry output and
// decode input. Holds up to DEPTH entries, drops everything on flush, and
// stops accepting after an entry carrying a fetch exception until the next
// flush.
// Optional macro FETCH_ENTRY_BUFFER_BYPASS_EN: when defined, an empty buffer
// forwards the incoming entry combinationally (zero-cycle latency).

module fetch_entry_buffer
  import fetch_entry_buffer_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           DEPTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  ariane_pkg::fetch_entry_t fetch_entry_i,
  input  logic                     fetch_entry_valid_i,
  output logic                     fetch_entry_ready_o,
  output ariane_pkg::fetch_entry_t fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     halted_o
);

  localparam int unsigned      DEPTH_W    = $clog2(DEPTH);
  localparam logic [DEPTH_W:0] FULL_COUNT = (DEPTH_W + 1)'(DEPTH);

  // Elaboration-time parameter checks.
  if (!depth_is_valid(DEPTH)) begin : g_bad_depth
    $error("fetch_entry_buffer: DEPTH must be a power of two >= 2");
  end
  if (CVA6Cfg.XLEN > 64) begin : g_bad_xlen
    $error("fetch_entry_buffer: XLEN wider than the 64-bit entry address");
  end

  ariane_pkg::fetch_entry_t mem_q [DEPTH];

  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               halt_q, halt_d;

  logic empty;
  logic push;   // upstream handshake
  logic pop;    // downstream handshake
  logic store;  // push that lands in the array
  logic take;   // pop that frees an array slot

  assign empty               = (count_q == '0);
  assign fetch_entry_ready_o = (count_q != FULL_COUNT) && !halt_q && !flush_i;
  assign push                = fetch_entry_valid_i && fetch_entry_ready_o;

`ifdef FETCH_ENTRY_BUFFER_BYPASS_EN
  // When empty, the input is forwarded; if decode takes it in the same
  // cycle it never touches the array. ready_o already folds in !flush_i.
  assign fetch_entry_valid_o = empty ? push : !flush_i;
  assign fetch_entry_o       = empty ? fetch_entry_i : mem_q[rd_ptr_q];
  assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;
  assign store               = push && !(empty && fetch_entry_ready_i);
  assign take                = pop && !empty;
`else
  assign fetch_entry_valid_o = !empty && !flush_i;
  assign fetch_entry_o       = mem_q[rd_ptr_q];
  assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;
  assign store               = push;
  assign take                = pop;
`endif

  assign usage_o  = count_q;
  assign halted_o = halt_q;

  // Next-state for pointers, count and halt; flush wins over everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      halt_d   = 1'b0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (take)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({store, take})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push && fetch_entry_i.ex.valid) halt_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= fetch_entry_i;
  end

endmodule

// File: tb/tb_fetch_entry_buffer.sv
// Testbench for fetch_entry_buffer: directed scenarios followed by random
// traffic, checked against a queue-based reference model.

module tb_fetch_entry_buffer;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_ENTRY_BUFFER_BYPASS_EN
  localparam int unsigned STREAM_USAGE = 0;
  localparam int unsigned STREAM_OUT   = 20;
`else
  localparam int unsigned STREAM_USAGE = 1;
  localparam int unsigned STREAM_OUT   = 19;
`endif

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  fetch_entry_t entry_i;
  logic         valid_i;
  logic         ready_o;
  fetch_entry_t entry_o;
  logic         valid_o;
  logic         ready_i;
  logic [2:0]   usage_o;
  logic         halted_o;

  int checks = 0;
  int errors = 0;

  fetch_entry_t model_q[$];
  bit           model_halt;
  bit           exp_valid, exp_ready;
  fetch_entry_t exp_entry;

  always #5 clk = ~clk;

  fetch_entry_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fetch_entry_i       (entry_i),
    .fetch_entry_valid_i (valid_i),
    .fetch_entry_ready_o (ready_o),
    .fetch_entry_o       (entry_o),
    .fetch_entry_valid_o (valid_o),
    .fetch_entry_ready_i (ready_i),
    .usage_o             (usage_o),
    .halted_o            (halted_o)
  );

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_entry(string tag, fetch_entry_t obs, fetch_entry_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t make_entry(logic [63:0] addr, logic exc);
    fetch_entry_t e;
    e.address     = addr;
    e.instruction = $urandom;
    e.ex.valid    = exc;
    e.ex.cause    = exc ? 64'd1 : 64'd0;
    e.ex.tval     = exc ? addr : 64'd0;
    return e;
  endfunction

  // Called just after a rising edge with inputs set. Checks outputs against
  // the model, then advances the model across the next rising edge.
  task automatic cycle();
    bit bypassed;
    #1;
    exp_ready = (model_q.size() < DEPTH) && !model_halt && !flush_i;
    exp_valid = (model_q.size() != 0) && !flush_i;
    exp_entry = (model_q.size() != 0) ? model_q[0] : '0;
`ifdef FETCH_ENTRY_BUFFER_BYPASS_EN
    if (model_q.size() == 0 && !flush_i) begin
      exp_valid = valid_i && exp_ready;
      exp_entry = entry_i;
    end
`endif
    check_val("ready_o", 32'(ready_o), 32'(exp_ready));
    check_val("valid_o", 32'(valid_o), 32'(exp_valid));
    check_val("usage_o", 32'(usage_o), 32'(model_q.size()));
    check_val("halted_o", 32'(halted_o), 32'(model_halt));
    if (exp_valid) check_entry("fetch_entry_o", entry_o, exp_entry);
    @(posedge clk);
    bypassed = 1'b0;
    if (flush_i) begin
      model_q.delete();
      model_halt = 1'b0;
    end else begin
      if (exp_valid && ready_i) begin
        if (model_q.size() != 0) void'(model_q.pop_front());
        else bypassed = 1'b1;
      end
      if (valid_i && exp_ready) begin
        if (!bypassed) model_q.push_back(entry_i);
        if (entry_i.ex.valid) model_halt = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    int n_out;
    logic [31:0] exp_addr;

    rst_ni  = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    entry_i = '0;
    model_halt = 1'b0;

    // Reset state
    #1;
    check_val("rst_ready", 32'(ready_o), 32'd1);
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_usage", 32'(usage_o), 32'd0);
    check_val("rst_halted", 32'(halted_o), 32'd0);
    #2 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      ready_i = 1'b0;
      entry_i = make_entry(64'h8000_0000 + 64'(4 * i), 1'b0);
      cycle();
    end
    valid_i = 1'b0;
    #1;
    check_val("fill_usage", 32'(usage_o), 32'd4);
    check_val("fill_ready", 32'(ready_o), 32'd0);
    cycle();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_addr = 32'h8000_0000 + 32'(4 * i);
      check_val("drain_valid", 32'(valid_o), 32'd1);
      check_val("drain_addr", entry_o.address[31:0], exp_addr);
      cycle();
    end
    ready_i = 1'b0;
    #1;
    check_val("drain_usage", 32'(usage_o), 32'd0);
    check_val("drain_valid_end", 32'(valid_o), 32'd0);
    cycle();

    // Streaming
    n_out = 0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      entry_i = make_entry(64'h9000_0000 + 64'(4 * i), 1'b0);
      #1;
      if (valid_o && ready_i) n_out++;
      cycle();
      check_val("stream_usage", 32'(usage_o), 32'(STREAM_USAGE));
    end
    check_val("stream_out", 32'(n_out), 32'(STREAM_OUT));
    valid_i = 1'b0;
    cycle();
    ready_i = 1'b0;
    cycle();

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      entry_i = make_entry(64'hA000_0000 + 64'(4 * i), 1'b0);
      cycle();
    end
    ready_i = 1'b1;
    entry_i = make_entry(64'hA000_0100, 1'b0);
    #1;
    check_val("full_ready", 32'(ready_o), 32'd0);
    check_val("full_valid", 32'(valid_o), 32'd1);
    cycle();
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    check_val("reopen_ready", 32'(ready_o), 32'd1);
    check_val("reopen_usage", 32'(usage_o), 32'd3);
    cycle();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    ready_i = 1'b0;

    // Exception halt
    valid_i = 1'b1;
    entry_i = make_entry(64'h8000_1000, 1'b1);
    cycle();
    entry_i = make_entry(64'h8000_1004, 1'b0);
    #1;
    check_val("halt_set", 32'(halted_o), 32'd1);
    check_val("halt_ready", 32'(ready_o), 32'd0);
    check_val("halt_usage", 32'(usage_o), 32'd1);
    cycle();
    cycle();
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    check_val("exc_delivered", 32'(entry_o.ex.valid), 32'd1);
    check_val("exc_addr", entry_o.address[31:0], 32'h8000_1000);
    cycle();
    ready_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check_val("flush_ready", 32'(ready_o), 32'd0);
    cycle();
    flush_i = 1'b0;
    #1;
    check_val("unhalt", 32'(halted_o), 32'd0);
    check_val("unhalt_ready", 32'(ready_o), 32'd1);
    check_val("unhalt_usage", 32'(usage_o), 32'd0);
    cycle();

    // Flush mid-stream
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      entry_i = make_entry(64'hB000_0000 + 64'(4 * i), 1'b0);
      cycle();
    end
    flush_i = 1'b1;
    ready_i = 1'b1;
    entry_i = make_entry(64'hB000_00F0, 1'b0);
    #1;
    check_val("fl_valid", 32'(valid_o), 32'd0);
    check_val("fl_ready", 32'(ready_o), 32'd0);
    cycle();
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    check_val("fl_usage", 32'(usage_o), 32'd0);
    check_val("fl_absent", 32'(valid_o), 32'd0);
    cycle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1;
      entry_i = make_entry(64'hC000_0000 + 64'(4 * i), 1'b0);
      cycle();
    end
    valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check_val("arst_usage", 32'(usage_o), 32'd0);
    check_val("arst_valid", 32'(valid_o), 32'd0);
    check_val("arst_ready", 32'(ready_o), 32'd1);
    model_q.delete();
    model_halt = 1'b0;
    @(posedge clk);
    #4 rst_ni = 1'b1;
    valid_i = 1'b1;
    entry_i = make_entry(64'hC000_1000, 1'b0);
    cycle();
    valid_i = 1'b0;
    #1;
    check_val("post_rst_push", 32'(usage_o), 32'd1);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 6);
      flush_i = ($urandom_range(0, 29) == 0);
      entry_i = make_entry({$urandom, $urandom}, $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
